// File: rtl/regbank_ctrl_pkg.sv
// Shared opcode, handshake-byte and state definitions for the UART register-bank controller.
package regbank_ctrl_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READA   = 2'b01;
    localparam logic [1:0] OP_READB   = 2'b10;
    localparam logic [1:0] OP_INVALID = 2'b11;

    localparam logic [1:0] END_SWAP = 2'b11;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_DATA,
        S_WRITE,
        S_READ_REQ,
        S_READ_CAP,
        S_TX_BYTE,
        S_TX_WAIT_LO,
        S_TX_WAIT_HI
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] endsel;
        logic [3:0] idx;
    } header_t;

endpackage

// File: rtl/regbank_uart_ctrl_if.sv
// UART byte stream plus reg_bank access port of the controller, seen from controller (master) or environment (slave).
interface regbank_uart_ctrl_if #(
    parameter int unsigned DATA_W = 64
);
    logic              rxready;
    logic [7:0]        dout;
    logic              txready;
    logic              txen;
    logic [7:0]        din;
    logic              regwen;
    logic [DATA_W-1:0] inA;
    logic [3:0]        selwreg;
    logic [1:0]        endreg;
    logic [3:0]        seloutA;
    logic [3:0]        seloutB;
    logic              cnstA;
    logic              cnstB;
    logic              enrregA;
    logic              enrregB;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;
    logic              busy;
    logic              ovr;

    modport master (
        input  rxready, dout, txready, outA, outB,
        output txen, din, regwen, inA, selwreg, endreg,
               seloutA, seloutB, cnstA, cnstB, enrregA, enrregB, busy, ovr
    );

    modport slave (
        output rxready, dout, txready, outA, outB,
        input  txen, din, regwen, inA, selwreg, endreg,
               seloutA, seloutB, cnstA, cnstB, enrregA, enrregB, busy, ovr
    );
endinterface

// File: rtl/regbank_ctrl_timer.sv
// Loadable down-counter: load restarts a TIMEOUT_CYC countdown, expire pulses once when it runs out.
module regbank_ctrl_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expire
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;
    logic             armed;

    always_ff @(posedge clock or posedge reset) begin : countdown
        if (reset) begin
            count  <= '0;
            armed  <= 1'b0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load) begin
                count <= CNT_W'(TIMEOUT_CYC);
                armed <= 1'b1;
            end else if (armed) begin
                if (count <= CNT_W'(1)) begin
                    expire <= 1'b1;
                    armed  <= 1'b0;
                    count  <= '0;
                end else begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regbank_uart_ctrl.sv
// UART command decoder driving a dual-read reg_bank; answers with ACK/NAK or read data.
// Optional inter-byte timeout in RX_DATA enabled by defining REGBANK_CTRL_TIMEOUT_EN.
module regbank_uart_ctrl
    import regbank_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input logic           clock,
    input logic           reset,
    regbank_uart_ctrl_if.master bus
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] ALL_TX  = CNT_W'(NBYTES);

    if ((DATA_W % 8) != 0 || DATA_W == 0 || TIMEOUT_CYC == 0) begin : g_bad_params
        $error("regbank_uart_ctrl: DATA_W must be a nonzero multiple of 8 and TIMEOUT_CYC nonzero");
    end

    state_t            state;
    header_t           hdr;
    header_t           rx_hdr_c;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_next_c;
    logic [CNT_W-1:0]  byte_cnt;
    logic              timeout_c;

    assign rx_hdr_c  = header_t'(bus.dout);
    assign rx_next_c = (rx_shift << 8) | DATA_W'(bus.dout);

    assign bus.cnstA = 1'b0;
    assign bus.cnstB = 1'b0;

`ifdef REGBANK_CTRL_TIMEOUT_EN
    logic timer_load_c;

    // Restart on the header that opens RX_DATA and on every accepted data byte.
    assign timer_load_c = bus.rxready &&
                          ((state == S_IDLE && rx_hdr_c.op == OP_WRITE && rx_hdr_c.endsel != END_SWAP) ||
                           state == S_RX_DATA);

    regbank_ctrl_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load_c),
        .expire (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin : fsm
        if (reset) begin
            state       <= S_IDLE;
            hdr         <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            byte_cnt    <= '0;
            bus.txen    <= 1'b0;
            bus.din     <= '0;
            bus.regwen  <= 1'b0;
            bus.inA     <= '0;
            bus.selwreg <= '0;
            bus.endreg  <= '0;
            bus.seloutA <= '0;
            bus.seloutB <= '0;
            bus.enrregA <= 1'b0;
            bus.enrregB <= 1'b0;
            bus.busy    <= 1'b0;
            bus.ovr     <= 1'b0;
        end else begin
            bus.txen    <= 1'b0;
            bus.regwen  <= 1'b0;
            bus.enrregA <= 1'b0;
            bus.enrregB <= 1'b0;
            // Bytes arriving while a command is being served are dropped and flagged.
            bus.ovr     <= bus.rxready && state != S_IDLE && state != S_RX_DATA;

            unique case (state)
                S_IDLE: begin
                    if (bus.rxready) begin
                        hdr      <= rx_hdr_c;
                        bus.busy <= 1'b1;
                        case (rx_hdr_c.op)
                            OP_WRITE: begin
                                if (rx_hdr_c.endsel == END_SWAP) begin
                                    state       <= S_WRITE;
                                    bus.regwen  <= 1'b1;
                                    bus.inA     <= rx_shift;
                                    bus.selwreg <= rx_hdr_c.idx;
                                    bus.endreg  <= rx_hdr_c.endsel;
                                end else begin
                                    state    <= S_RX_DATA;
                                    byte_cnt <= '0;
                                end
                            end
                            OP_READA: begin
                                state       <= S_READ_REQ;
                                bus.seloutA <= rx_hdr_c.idx;
                                bus.enrregA <= 1'b1;
                            end
                            OP_READB: begin
                                state       <= S_READ_REQ;
                                bus.seloutB <= rx_hdr_c.idx;
                                bus.enrregB <= 1'b1;
                            end
                            OP_INVALID: begin
                                state    <= S_TX_BYTE;
                                tx_shift <= DATA_W'(NAK_BYTE) << (DATA_W - 8);
                                byte_cnt <= CNT_W'(1);
                            end
                        endcase
                    end
                end

                S_RX_DATA: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (bus.rxready) begin
                        rx_shift <= rx_next_c;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_RX) begin
                            state       <= S_WRITE;
                            bus.regwen  <= 1'b1;
                            bus.inA     <= rx_next_c;
                            bus.selwreg <= hdr.idx;
                            bus.endreg  <= hdr.endsel;
                        end
                    end else if (timeout_c) begin
                        state    <= S_TX_BYTE;
                        tx_shift <= DATA_W'(NAK_BYTE) << (DATA_W - 8);
                        byte_cnt <= CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    state    <= S_TX_BYTE;
                    tx_shift <= DATA_W'(ACK_BYTE) << (DATA_W - 8);
                    byte_cnt <= CNT_W'(1);
                end

                S_READ_REQ: state <= S_READ_CAP;

                S_READ_CAP: begin
                    state    <= S_TX_BYTE;
                    tx_shift <= (hdr.op == OP_READA) ? bus.outA : bus.outB;
                    byte_cnt <= ALL_TX;
                end

                S_TX_BYTE: begin
                    if (bus.txready) begin
                        state    <= S_TX_WAIT_LO;
                        bus.txen <= 1'b1;
                        bus.din  <= tx_shift[DATA_W-1 -: 8];
                        tx_shift <= tx_shift << 8;
                        byte_cnt <= byte_cnt - 1'b1;
                    end
                end

                S_TX_WAIT_LO: begin
                    if (!bus.txready) state <= S_TX_WAIT_HI;
                end

                S_TX_WAIT_HI: begin
                    if (bus.txready) begin
                        if (byte_cnt == '0) begin
                            state    <= S_IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= S_TX_BYTE;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/regbank_uart_ctrl.md
REGBANK_UART_CTRL -- requirements
Module: regbank_uart_ctrl

Interface
REQ-001 Parameter DATA_W, 64, reg_bank data width; SHALL be a multiple of 8.
REQ-002 Parameter TIMEOUT_CYC, 1000000, inter-byte timeout in clock cycles (10 ms at 100 MHz).
REQ-003 clock  in  1  master clock, active on posedge.
REQ-004 reset  in  1  master reset, asynchronous, active-high.
REQ-005 rxready  in  1  UART received byte valid on dout (one-cycle pulse).
REQ-006 dout  in  8  UART received byte.
REQ-007 txready  in  1  UART ready to accept a byte.
REQ-008 txen  out  1  one-cycle pulse loading din into the UART.
REQ-009 din  out  8  byte to transmit.
REQ-010 regwen / inA / selwreg / endreg  out  1 / DATA_W / 4 / 2  reg_bank write port.
REQ-011 seloutA, seloutB  out  4  reg_bank read selects; cnstA, cnstB  out  1  constant selects, driven 0.
REQ-012 enrregA, enrregB  out  1  reg_bank output-register load enables.
REQ-013 outA, outB  in  DATA_W  registered reg_bank read data.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 ovr  out  1  one-cycle pulse when rxready arrives outside IDLE/RX_DATA; the byte SHALL be dropped.

Function
REQ-016 Header byte: [7:6] op (00 WRITE, 01 READA, 10 READB, 11 invalid), [5:4] endreg, [3:0] register index.
REQ-017 States: IDLE, RX_DATA, WRITE, READ_REQ, READ_CAP, TX_BYTE, TX_WAIT_LO, TX_WAIT_HI.
REQ-018 WRITE with endreg != 11: RX_DATA collects DATA_W/8 bytes, MSB first, into a shift register.
REQ-019 WRITE with endreg == 11 (swap): SHALL skip RX_DATA and enter WRITE the cycle after the header.
REQ-020 WRITE state: regwen=1 for exactly one cycle with inA, selwreg, endreg held; then transmit ACK 0x06.
REQ-021 READA/READB: READ_REQ drives seloutX=index, enrregX=1 for one cycle; READ_CAP captures outX the next cycle; then transmit DATA_W/8 bytes MSB first.
REQ-022 op 11: no reg_bank access; transmit NAK 0x15.
REQ-023 Transmit handshake: assert txen only with txready=1 (TX_BYTE); then wait txready=0 (TX_WAIT_LO), then txready=1 (TX_WAIT_HI) before next byte; after last byte return to IDLE.
REQ-024 regwen, enrregA, enrregB, txen SHALL never be high in the same cycle as each other.
REQ-025 rxready and timeout expiry in the same cycle: the byte SHALL be accepted and the timer restarted.
REQ-026 selwreg, seloutA, seloutB SHALL hold their last value between transactions.

Reset
REQ-027 On reset: state IDLE; all outputs 0; shift register, byte counter, timer cleared; takes effect asynchronously, including mid-transaction.

Configuration
REQ-028 Macro REGBANK_CTRL_TIMEOUT_EN defined: in RX_DATA, TIMEOUT_CYC cycles without rxready SHALL abort (no regwen), transmit NAK 0x15, return to IDLE.
REQ-029 Macro undefined: no timer logic; RX_DATA waits indefinitely.

Structure
REQ-030 Package regbank_ctrl_pkg: opcode constants, ACK/NAK constants, state encoding.
REQ-031 Sub-module regbank_ctrl_timer: loadable down-counter (load, expire), instantiated only under REGBANK_CTRL_TIMEOUT_EN.

Verification
REQ-032 Bytes 0x03, 00 00 00 00 00 FF 00 FF -> single regwen pulse, selwreg=3, endreg=00, inA=0x0000000000FF00FF; tx 0x06.
REQ-033 Then byte 0x43 -> enrregA pulse with seloutA=3; tx 00 00 00 00 00 FF 00 FF in order.
REQ-034 Byte 0x33 -> regwen next cycle with endreg=11, selwreg=3, no data bytes consumed; tx 0x06.
REQ-035 Byte 0xC0 -> tx 0x15, no regwen/enrreg; byte received during tx -> ovr pulse, state unaffected.
REQ-036 Header 0x05 plus 3 bytes, then idle > TIMEOUT_CYC (test value 100) -> with macro: tx 0x15, IDLE, no regwen; without: busy stays 1.
REQ-037 Reset asserted during READA transmission -> txen, busy, all outputs 0 before next clock edge; next 0x43 completes normally.
